// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared state, operation and variable-select encodings for the CORDIC controller
package cordic_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        ITER_SEL,
        VAR_SEL,
        ADD_START,
        ADD_WAIT,
        ADD_ACK,
        RES_SEL,
        OUT_LATCH,
        DONE
    } state_t;

    localparam logic [1:0] OP_COS    = 2'b00;
    localparam logic [1:0] OP_SIN    = 2'b01;
    localparam logic [1:0] OP_SINCOS = 2'b10;

    localparam logic [1:0] VAR_X = 2'b00;
    localparam logic [1:0] VAR_Y = 2'b01;
    localparam logic [1:0] VAR_Z = 2'b10;

endpackage

// File: rtl/cordic_quad_sel.sv
// rtl/cordic_quad_sel.sv - picks X or Y as the output variable from operation, quadrant and phase
module cordic_quad_sel (
    input  logic [1:0] operation,
    input  logic [1:0] shift_region_flag,
    input  logic       out_sel,
    output logic       sel_mux_3
);
    import cordic_pkg::*;

    logic sin_out;
    logic mid_region;

    // In quadrants 01/10 cos and sin swap between the X and Y datapaths.
    always_comb begin
        sin_out    = (operation == OP_SIN) || ((operation == OP_SINCOS) && out_sel);
        mid_region = (shift_region_flag == 2'b01) || (shift_region_flag == 2'b10);
        sel_mux_3  = mid_region ^ sin_out;
    end

endmodule

// File: rtl/cordic_seq_ctrl.sv
// rtl/cordic_seq_ctrl.sv - CORDIC iteration sequencer; macro CORDIC_TIMEOUT_EN adds an ADD_WAIT timeout
module cordic_seq_ctrl #(
    parameter int N_ITER      = 16,
    parameter int ITER_W      = 6,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              beg_fsm_cordic,
    input  logic              ack_fsm_cordic,
    input  logic [1:0]        operation,
    input  logic [1:0]        shift_region_flag,
    input  logic              exception,
    input  logic              ready_add_subt,
    output logic              beg_add_subt,
    output logic              ack_add_subt,
    output logic              sel_mux_1,
    output logic [1:0]        sel_mux_2,
    output logic              sel_mux_3,
    output logic [ITER_W-1:0] iter_idx,
    output logic              enab_RB1,
    output logic              enab_RB2,
    output logic              enab_RB3,
    output logic              enab_d_ff_Xn,
    output logic              enab_d_ff_Yn,
    output logic              enab_d_ff_Zn,
    output logic              enab_d_ff_out,
    output logic              out_sel,
    output logic              ready_cordic,
    output logic              busy,
    output logic              error
);
    import cordic_pkg::*;

    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(N_ITER - 1);

    state_t            state, state_nxt;
    logic [ITER_W-1:0] iter_cnt;
    logic [1:0]        var_cnt;
    logic [1:0]        op_q;
    logic              err_q;
    logic              out_sel_q;
    logic              quad_sel;
    logic              timeout;

`ifdef CORDIC_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
    logic [WAIT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!reset || state != ADD_WAIT) wait_cnt <= '0;
        else                             wait_cnt <= wait_cnt + 1'b1;
    end

    assign timeout = (state == ADD_WAIT) && !ready_add_subt &&
                     (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            iter_cnt  <= '0;
            var_cnt   <= VAR_X;
            op_q      <= OP_COS;
            err_q     <= 1'b0;
            out_sel_q <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (beg_fsm_cordic) begin
                    err_q     <= 1'b0;
                    op_q      <= operation;
                    out_sel_q <= (operation == OP_SIN);
                end
                LOAD: begin
                    iter_cnt <= '0;
                    var_cnt  <= VAR_X;
                end
                ITER_SEL: begin
                    var_cnt <= VAR_X;
                    if (exception) err_q <= 1'b1;
                end
                ADD_WAIT: if (timeout) err_q <= 1'b1;
                ADD_ACK: begin
                    if (var_cnt != VAR_Z)          var_cnt  <= var_cnt + 2'd1;
                    else if (iter_cnt != LAST_ITER) iter_cnt <= iter_cnt + 1'b1;
                end
                DONE: if (ack_fsm_cordic && op_q == OP_SINCOS && !out_sel_q) out_sel_q <= 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt     = state;
        beg_add_subt  = 1'b0;
        ack_add_subt  = 1'b0;
        enab_RB1      = 1'b0;
        enab_RB2      = 1'b0;
        enab_RB3      = 1'b0;
        enab_d_ff_Xn  = 1'b0;
        enab_d_ff_Yn  = 1'b0;
        enab_d_ff_Zn  = 1'b0;
        enab_d_ff_out = 1'b0;
        ready_cordic  = 1'b0;
        case (state)
            IDLE: if (beg_fsm_cordic) state_nxt = LOAD;
            LOAD: begin
                enab_RB1  = 1'b1;
                state_nxt = ITER_SEL;
            end
            // The variable counter is cleared here, so this cycle also serves as the X select.
            ITER_SEL: begin
                if (exception) begin
                    state_nxt = IDLE;
                end else begin
                    enab_RB2  = 1'b1;
                    enab_RB3  = 1'b1;
                    state_nxt = ADD_START;
                end
            end
            VAR_SEL: state_nxt = ADD_START;
            ADD_START: begin
                beg_add_subt = 1'b1;
                state_nxt    = ADD_WAIT;
            end
            ADD_WAIT: begin
                if (ready_add_subt) begin
                    case (var_cnt)
                        VAR_X:   enab_d_ff_Xn = 1'b1;
                        VAR_Y:   enab_d_ff_Yn = 1'b1;
                        default: enab_d_ff_Zn = 1'b1;
                    endcase
                    state_nxt = ADD_ACK;
                end else if (timeout) begin
                    ack_add_subt = 1'b1;
                    state_nxt    = IDLE;
                end
            end
            ADD_ACK: begin
                ack_add_subt = 1'b1;
                if (var_cnt != VAR_Z)           state_nxt = VAR_SEL;
                else if (iter_cnt != LAST_ITER) state_nxt = ITER_SEL;
                else                            state_nxt = RES_SEL;
            end
            RES_SEL: state_nxt = OUT_LATCH;
            OUT_LATCH: begin
                enab_d_ff_out = 1'b1;
                state_nxt     = DONE;
            end
            DONE: begin
                ready_cordic = 1'b1;
                if (ack_fsm_cordic)
                    state_nxt = (op_q == OP_SINCOS && !out_sel_q) ? RES_SEL : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    cordic_quad_sel u_quad_sel (
        .operation         (op_q),
        .shift_region_flag (shift_region_flag),
        .out_sel           (out_sel_q),
        .sel_mux_3         (quad_sel)
    );

    assign busy      = (state != IDLE);
    assign error     = err_q;
    assign out_sel   = out_sel_q;
    assign iter_idx  = iter_cnt;
    assign sel_mux_1 = busy && (iter_cnt != '0);
    assign sel_mux_2 = busy ? var_cnt : VAR_X;
    assign sel_mux_3 = quad_sel && (state == RES_SEL || state == OUT_LATCH || state == DONE);

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// tb/tb_cordic_seq_ctrl.sv - directed scoreboard bench for cordic_seq_ctrl
module tb_cordic_seq_ctrl;

    localparam int N_ITER = 16;
    localparam int ITER_W = 6;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              beg_fsm_cordic = 1'b0;
    logic              ack_fsm_cordic = 1'b0;
    logic [1:0]        operation = 2'b00;
    logic [1:0]        shift_region_flag = 2'b00;
    logic              exception = 1'b0;
    logic              ready_add_subt = 1'b0;
    logic              beg_add_subt, ack_add_subt, sel_mux_1, sel_mux_3;
    logic [1:0]        sel_mux_2;
    logic [ITER_W-1:0] iter_idx;
    logic              enab_RB1, enab_RB2, enab_RB3;
    logic              enab_d_ff_Xn, enab_d_ff_Yn, enab_d_ff_Zn, enab_d_ff_out;
    logic              out_sel, ready_cordic, busy, error;

    int checks = 0;
    int errors = 0;
    int xn_cnt = 0, yn_cnt = 0, zn_cnt = 0, out_cnt = 0, ack_cnt = 0;
    logic adder_en = 1'b1;
    logic pend = 1'b0;
    logic rdy_d = 1'b0;
    logic [1:0] exp_q[$];
    logic [1:0] exp_e;

    cordic_seq_ctrl #(.N_ITER(N_ITER), .ITER_W(ITER_W), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .reset(reset),
        .beg_fsm_cordic(beg_fsm_cordic), .ack_fsm_cordic(ack_fsm_cordic),
        .operation(operation), .shift_region_flag(shift_region_flag),
        .exception(exception), .ready_add_subt(ready_add_subt),
        .beg_add_subt(beg_add_subt), .ack_add_subt(ack_add_subt),
        .sel_mux_1(sel_mux_1), .sel_mux_2(sel_mux_2), .sel_mux_3(sel_mux_3),
        .iter_idx(iter_idx),
        .enab_RB1(enab_RB1), .enab_RB2(enab_RB2), .enab_RB3(enab_RB3),
        .enab_d_ff_Xn(enab_d_ff_Xn), .enab_d_ff_Yn(enab_d_ff_Yn), .enab_d_ff_Zn(enab_d_ff_Zn),
        .enab_d_ff_out(enab_d_ff_out), .out_sel(out_sel),
        .ready_cordic(ready_cordic), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outputs();
        return 32'({beg_add_subt, ack_add_subt, sel_mux_1, sel_mux_2, sel_mux_3, iter_idx,
                    enab_RB1, enab_RB2, enab_RB3, enab_d_ff_Xn, enab_d_ff_Yn, enab_d_ff_Zn,
                    enab_d_ff_out, out_sel, ready_cordic, busy, error});
    endfunction

    // Adder model: result valid one cycle after the start pulse.
    always @(posedge clk) begin
        #1;
        ready_add_subt = pend;
        pend = beg_add_subt && adder_en;
    end

    // Scoreboard and pulse monitor.
    always @(negedge clk) begin
        if (ready_cordic && !rdy_d) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_e = exp_q.pop_front();
                check("out_sel_sel_mux_3", 32'({out_sel, sel_mux_3}), 32'(exp_e));
            end
        end
        rdy_d = ready_cordic;
        if (enab_d_ff_Xn || enab_d_ff_Yn || enab_d_ff_Zn)
            check("xyz_onehot", 32'($countones({enab_d_ff_Xn, enab_d_ff_Yn, enab_d_ff_Zn})), 32'd1);
        if (enab_d_ff_Xn) xn_cnt++;
        if (enab_d_ff_Yn) yn_cnt++;
        if (enab_d_ff_Zn) zn_cnt++;
        if (enab_d_ff_out) out_cnt++;
        if (ack_add_subt) ack_cnt++;
    end

    // Expected {out_sel, sel_mux_3}: quadrants 01/10 swap X and Y.
    task automatic push_expect(input logic [1:0] op, input logic [1:0] region);
        logic mid;
        mid = (region == 2'b01) || (region == 2'b10);
        if (op == 2'b01) begin
            exp_q.push_back({1'b1, ~mid});
        end else if (op == 2'b10) begin
            exp_q.push_back({1'b0, mid});
            exp_q.push_back({1'b1, ~mid});
        end else begin
            exp_q.push_back({1'b0, mid});
        end
    endtask

    task automatic start_op(input logic [1:0] op, input logic [1:0] region, input bit expect_result);
        xn_cnt = 0; yn_cnt = 0; zn_cnt = 0; out_cnt = 0; ack_cnt = 0;
        operation = op;
        shift_region_flag = region;
        if (expect_result) push_expect(op, region);
        beg_fsm_cordic = 1'b1;
        @(negedge clk);
        beg_fsm_cordic = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ready_cordic && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(ready_cordic), 32'd1);
    endtask

    task automatic ack_result();
        ack_fsm_cordic = 1'b1;
        @(negedge clk);
        ack_fsm_cordic = 1'b0;
    endtask

    task automatic wait_iter(input int k);
        int n = 0;
        while (iter_idx != ITER_W'(k) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("wait_iter", 32'(iter_idx), 32'(k));
    endtask

    initial begin
        int cnt;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outputs(), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // cos, region 00: latency, beg ignored while busy, pulse counts
        start_op(2'b00, 2'b00, 1'b1);
        cnt = 1;
        while (!ready_cordic && cnt < 400) begin
            @(negedge clk);
            cnt++;
            if (cnt == 50) beg_fsm_cordic = 1'b1;
            if (cnt == 51) beg_fsm_cordic = 1'b0;
        end
        check("cos_latency", 32'(cnt), 32'(1 + N_ITER * 3 * 4 + 3));
        check("cos_sel_mux_3", 32'(sel_mux_3), 32'd0);
        check("cos_x_pulses", 32'(xn_cnt), 32'(N_ITER));
        check("cos_y_pulses", 32'(yn_cnt), 32'(N_ITER));
        check("cos_z_pulses", 32'(zn_cnt), 32'(N_ITER));
        check("cos_ack_pulses", 32'(ack_cnt), 32'(N_ITER * 3));
        ack_result();
        check("cos_idle_busy", 32'(busy), 32'd0);
        check("cos_out_pulses", 32'(out_cnt), 32'd1);

        // sin, quadrant 01 and 00
        start_op(2'b01, 2'b01, 1'b1);
        wait_ready("sin01_ready");
        check("sin01_sel_mux_3", 32'(sel_mux_3), 32'd0);
        ack_result();
        start_op(2'b01, 2'b00, 1'b1);
        wait_ready("sin00_ready");
        check("sin00_sel_mux_3", 32'(sel_mux_3), 32'd1);
        ack_result();
        check("sin_idle", 32'(busy), 32'd0);

        // sincos: two result phases
        start_op(2'b10, 2'b10, 1'b1);
        wait_ready("sincos_ready0");
        check("sincos_out_sel0", 32'(out_sel), 32'd0);
        ack_result();
        check("sincos_reentered", 32'(ready_cordic), 32'd0);
        wait_ready("sincos_ready1");
        check("sincos_out_sel1", 32'(out_sel), 32'd1);
        ack_result();
        check("sincos_out_pulses", 32'(out_cnt), 32'd2);
        check("sincos_idle", 32'(busy), 32'd0);

        // exception during ITER_SEL of iteration 5
        start_op(2'b00, 2'b00, 1'b0);
        wait_iter(5);
        exception = 1'b1;
        @(negedge clk);
        exception = 1'b0;
        check("exc_busy", 32'(busy), 32'd0);
        check("exc_error", 32'(error), 32'd1);
        @(negedge clk);
        check("exc_error_sticky", 32'(error), 32'd1);
        start_op(2'b00, 2'b11, 1'b1);
        check("exc_error_cleared", 32'(error), 32'd0);
        wait_ready("after_exc_ready");
        ack_result();

        // reset during ADD_WAIT of iteration 3
        start_op(2'b00, 2'b00, 1'b0);
        wait_iter(3);
        adder_en = 1'b0;
        @(negedge clk);
        check("rst_add_start", 32'(beg_add_subt), 32'd1);
        @(negedge clk);
        check("rst_in_add_wait", 32'({busy, beg_add_subt, ack_add_subt}), 32'b100);
        reset = 1'b0;
        @(negedge clk);
        check("rst_outputs", all_outputs(), 32'd0);
        check("rst_ack_count", 32'(ack_cnt), 32'd9);
        reset = 1'b1;
        adder_en = 1'b1;
        @(negedge clk);

`ifdef CORDIC_TIMEOUT_EN
        // adder never answers: timeout after 8 ADD_WAIT cycles
        adder_en = 1'b0;
        start_op(2'b00, 2'b00, 1'b0);
        cnt = 0;
        while (!beg_add_subt && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("to_add_start", 32'(beg_add_subt), 32'd1);
        cnt = 0;
        while (!ack_add_subt && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("to_wait_cycles", 32'(cnt), 32'd8);
        @(negedge clk);
        check("to_state", 32'({busy, error, ack_add_subt}), 32'b010);
        adder_en = 1'b1;
        @(negedge clk);
`endif

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
